// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode
// Brief    : IF/ID pipeline register and decode stage with a load-use bubble
//            and a sticky trap on illegal instructions.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        pc_write_en,
    output logic        stall,
    output logic        halted,
    output logic [31:0] pc_q,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] target_addr,
    output logic        ctrl_valid,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  reg_dst,
    output logic [2:0]  alu_op,
    output logic        branch,
    output logic        jr,
    output logic        jl
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] instr_q;
    logic        valid_q;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        known;
    logic        uses_rt;
    logic        illegal;
    logic        hazard;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_alu_src;
    logic        dec_mem_to_reg;
    logic [1:0]  dec_reg_dst;
    logic [2:0]  dec_alu_op;
    logic        dec_branch;
    logic        dec_jr;
    logic        dec_jl;

    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign imm16       = instr_q[15:0];
    assign target_addr = instr_q[25:0];

    always_comb begin
        known          = 1'b0;
        uses_rt        = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_dst    = 2'd0;
        dec_alu_op     = 3'd0;
        dec_branch     = 1'b0;
        dec_jr         = 1'b0;
        dec_jl         = 1'b0;
        case (op)
            6'h00: begin
                uses_rt = 1'b1;
                case (funct)
                    6'h20: begin known = 1'b1; dec_reg_write = 1'b1; dec_reg_dst = 2'd1; end
                    6'h22: begin known = 1'b1; dec_reg_write = 1'b1; dec_reg_dst = 2'd1; dec_alu_op = 3'd1; end
                    6'h2A: begin known = 1'b1; dec_reg_write = 1'b1; dec_reg_dst = 2'd1; dec_alu_op = 3'd3; end
                    6'h08: begin known = 1'b1; dec_jr = 1'b1; end
                    // Only the all-zero sll is accepted, as the pipeline NOP.
                    6'h00: known = (instr_q == 32'h0000_0000);
                    default: known = 1'b0;
                endcase
            end
            6'h23: begin
                known = 1'b1; dec_reg_write = 1'b1; dec_mem_read = 1'b1;
                dec_alu_src = 1'b1; dec_mem_to_reg = 1'b1;
            end
            6'h2B: begin known = 1'b1; uses_rt = 1'b1; dec_mem_write = 1'b1; dec_alu_src = 1'b1; end
            6'h08: begin known = 1'b1; dec_reg_write = 1'b1; dec_alu_src = 1'b1; end
            6'h0E: begin known = 1'b1; dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 3'd2; end
            6'h05: begin known = 1'b1; uses_rt = 1'b1; dec_branch = 1'b1; dec_alu_op = 3'd1; end
            6'h02: begin known = 1'b1; dec_jl = 1'b1; end
            6'h03: begin known = 1'b1; dec_jl = 1'b1; dec_reg_write = 1'b1; dec_reg_dst = 2'd2; end
            default: known = 1'b0;
        endcase
    end

    assign illegal = valid_q & ~known;

    // A concurrent flush squashes the dependent instruction, so no bubble is needed.
    assign hazard = (state == RUN) & valid_q & ~flush & ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == rs) | ((ex_rt == rt) & uses_rt));

    assign ctrl_valid  = valid_q & (state != HALT) & ~hazard & ~illegal;
    assign stall       = hazard;
    assign pc_write_en = ~hazard & (state != HALT);
    assign halted      = (state == HALT);

    assign reg_write   = ctrl_valid & dec_reg_write;
    assign mem_read    = ctrl_valid & dec_mem_read;
    assign mem_write   = ctrl_valid & dec_mem_write;
    assign alu_src     = ctrl_valid & dec_alu_src;
    assign mem_to_reg  = ctrl_valid & dec_mem_to_reg;
    assign reg_dst     = ctrl_valid ? dec_reg_dst : 2'd0;
    assign alu_op      = ctrl_valid ? dec_alu_op : 3'd0;
    assign branch      = ctrl_valid & dec_branch;
    assign jr          = ctrl_valid & dec_jr;
    assign jl          = ctrl_valid & dec_jl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
            state   <= RUN;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (flush) begin
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        state   <= RUN;
                    end else if (hazard) begin
                        state   <= STALL;
                    end else begin
                        instr_q <= in_valid ? instr_in : NOP_WORD;
                        pc_q    <= pc_in;
                        valid_q <= in_valid;
                        state   <= (state == RUN && illegal) ? HALT : RUN;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode
// Brief    : Scoreboard bench for the IF/ID register and decode stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in, pc_in;
    logic        in_valid, flush, ex_mem_read;
    logic [4:0]  ex_rt;
    logic        pc_write_en, stall, halted, ctrl_valid;
    logic [31:0] pc_q;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] target_addr;
    logic        reg_write, mem_read, mem_write, alu_src, mem_to_reg;
    logic [1:0]  reg_dst;
    logic [2:0]  alu_op;
    logic        branch, jr, jl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .pc_write_en(pc_write_en), .stall(stall), .halted(halted), .pc_q(pc_q),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target_addr(target_addr),
        .ctrl_valid(ctrl_valid), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .alu_op(alu_op), .branch(branch), .jr(jr), .jl(jl)
    );

    // {reg_write, mem_read, mem_write, alu_src, mem_to_reg, reg_dst, alu_op, branch, jr, jl}
    wire [12:0] obs_ctrl = {reg_write, mem_read, mem_write, alu_src, mem_to_reg,
                            reg_dst, alu_op, branch, jr, jl};
    // {ctrl_valid, stall, pc_write_en, halted}
    wire [3:0]  obs_st   = {ctrl_valid, stall, pc_write_en, halted};

    localparam logic [12:0] C_NONE = 13'b0000000000000;
    localparam logic [12:0] C_ADDI = 13'b1001000000000;
    localparam logic [12:0] C_XORI = 13'b1001000010000;
    localparam logic [12:0] C_ADD  = 13'b1000001000000;
    localparam logic [12:0] C_LW   = 13'b1101100000000;
    localparam logic [12:0] C_SW   = 13'b0011000000000;
    localparam logic [12:0] C_BNE  = 13'b0000000001100;
    localparam logic [12:0] C_JAL  = 13'b1000010000001;
    localparam logic [12:0] C_JR   = 13'b0000000000010;

    localparam logic [3:0] S_OK    = 4'b1010;
    localparam logic [3:0] S_BUB   = 4'b0010;
    localparam logic [3:0] S_STALL = 4'b0100;
    localparam logic [3:0] S_HALT  = 4'b0001;
    localparam logic [3:0] M_ALL   = 4'b1111;

    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_ADD9 = 32'h0009_5020;
    localparam logic [31:0] I_SW9  = 32'hAC09_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_XORI = 32'h3842_00FF;
    localparam logic [31:0] I_LW   = 32'h8C05_0004;
    localparam logic [31:0] I_BNE  = 32'h1485_0003;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;

    typedef struct {
        string       name;
        logic [12:0] ctrl;
        logic [3:0]  st;
        logic [3:0]  mask;
        bit          chk_f;
        logic [31:0] pcq;
        logic [4:0]  rtv;
        logic [15:0] imm;
        logic [25:0] tgt;
    } exp_t;

    exp_t sb[$];

    task automatic expect_out(input string n, input logic [12:0] c, input logic [3:0] s,
                              input logic [3:0] m, input bit f, input logic [31:0] p,
                              input logic [4:0] r, input logic [15:0] i, input logic [25:0] t);
        exp_t e;
        e.name = n; e.ctrl = c; e.st = s; e.mask = m; e.chk_f = f;
        e.pcq = p; e.rtv = r; e.imm = i; e.tgt = t;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, compare the decode outputs against the next
    // scoreboard entry, then advance to the following falling edge.
    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                         input logic fl, input logic mr, input logic [4:0] er);
        exp_t e;
        instr_in = ins; pc_in = pc; in_valid = v; flush = fl; ex_mem_read = mr; ex_rt = er;
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty got=none required=entry");
        end else begin
            e = sb.pop_front();
            if (e.mask[3]) begin
                total++;
                if (obs_ctrl !== e.ctrl) begin
                    bad++;
                    $display("FAIL %s ctrl got=%b required=%b", e.name, obs_ctrl, e.ctrl);
                end
            end
            total++;
            if ((obs_st & e.mask) !== (e.st & e.mask)) begin
                bad++;
                $display("FAIL %s status got=%b required=%b", e.name, obs_st & e.mask, e.st & e.mask);
            end
            if (e.chk_f) begin
                total++;
                if (pc_q !== e.pcq) begin
                    bad++; $display("FAIL %s pc_q got=%h required=%h", e.name, pc_q, e.pcq);
                end
                total++;
                if (rt !== e.rtv) begin
                    bad++; $display("FAIL %s rt got=%0d required=%0d", e.name, rt, e.rtv);
                end
                total++;
                if (imm16 !== e.imm) begin
                    bad++; $display("FAIL %s imm16 got=%h required=%h", e.name, imm16, e.imm);
                end
                total++;
                if (target_addr !== e.tgt) begin
                    bad++; $display("FAIL %s target got=%h required=%h", e.name, target_addr, e.tgt);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        expect_out("reset", C_NONE, S_BUB, M_ALL, 1, 32'd0, 5'd0, 16'd0, 26'd0);
        cycle(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        expect_out("post_reset", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd4, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("addi", C_ADDI, S_OK, M_ALL, 1, 32'd4, 5'd8, 16'd5, 26'h008_0005);
        cycle(I_ADD9, 32'd8, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_load_use();
        expect_out("hazard_rs_rd", C_NONE, S_STALL, M_ALL, 1, 32'd8, 5'd9, 16'h5020, 26'h009_5020);
        cycle(I_SW9, 32'd16, 1'b1, 1'b0, 1'b1, 5'd9);
        expect_out("stall_release", C_ADD, S_OK, M_ALL, 1, 32'd8, 5'd9, 16'h5020, 26'h009_5020);
        cycle(I_ADD9, 32'd12, 1'b1, 1'b0, 1'b1, 5'd9);
        expect_out("ex_rt_zero", C_ADD, S_OK, M_ALL, 1, 32'd12, 5'd9, 16'h5020, 26'h009_5020);
        cycle(I_SW9, 32'd16, 1'b1, 1'b0, 1'b1, 5'd0);
        expect_out("hazard_sw_rt", C_NONE, S_STALL, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_JAL, 32'd20, 1'b1, 1'b0, 1'b1, 5'd9);
        expect_out("sw_release", C_SW, S_OK, M_ALL, 1, 32'd16, 5'd9, 16'd0, 26'h009_0000);
        cycle(I_JAL, 32'd20, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_jal_flush();
        expect_out("jal", C_JAL, S_OK, M_ALL, 1, 32'd20, 5'd0, 16'h0010, 26'h000_0010);
        cycle(I_XORI, 32'd24, 1'b1, 1'b1, 1'b0, 5'd0);
        expect_out("flushed", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADD9, 32'd28, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_flush_hazard();
        expect_out("flush_beats_hazard", C_NONE, 4'b0010, 4'b0111, 0, 0, 0, 0, 0);
        cycle(I_JR, 32'd32, 1'b1, 1'b1, 1'b1, 5'd9);
        expect_out("nop_after_flush", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_JR, 32'd36, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("jr", C_JR, S_OK, M_ALL, 1, 32'd36, 5'd0, 16'h0008, 26'h3E0_0008);
        cycle(I_XORI, 32'd40, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_back_to_back();
        expect_out("xori", C_XORI, S_OK, M_ALL, 1, 32'd40, 5'd2, 16'h00FF, 26'h042_00FF);
        cycle(I_LW, 32'd44, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("lw", C_LW, S_OK, M_ALL, 1, 32'd44, 5'd5, 16'h0004, 26'h005_0004);
        cycle(I_BNE, 32'd48, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("bne", C_BNE, S_OK, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd50, 1'b0, 1'b0, 1'b0, 5'd0);
        expect_out("invalid_slot", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ILL, 32'd52, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_illegal();
        expect_out("illegal_seen", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd56, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("halted", C_NONE, S_HALT, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd60, 1'b1, 1'b1, 1'b0, 5'd0);
        expect_out("halted_after_flush", C_NONE, S_HALT, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd64, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("halted_sticky", C_NONE, S_HALT, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd64, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b0;
        expect_out("reset_mid_halt", C_NONE, S_BUB, M_ALL, 1, 32'd0, 5'd0, 16'd0, 26'd0);
        cycle(I_ADDI, 32'd68, 1'b1, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;
        expect_out("after_rerelease", C_NONE, S_BUB, M_ALL, 0, 0, 0, 0, 0);
        cycle(I_ADDI, 32'd72, 1'b1, 1'b0, 1'b0, 5'd0);
        expect_out("addi_after_halt", C_ADDI, S_OK, M_ALL, 1, 32'd72, 5'd8, 16'd5, 26'h008_0005);
        cycle(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0; instr_in = 32'd0; pc_in = 32'd0; in_valid = 1'b0;
        flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_load_use();
        test_jal_flush();
        test_flush_hazard();
        test_back_to_back();
        test_illegal();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
